// File: rtl/sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_responder: clocked async-SRAM device model with read latency,       |
// | minimum write pulse, byte lanes and sticky protocol error. Rev 1.0       |
// +--------------------------------------------------------------------------+
module sram_responder #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CE_N,
  input  logic              OE_N,
  input  logic              WE_N,
  input  logic              LB_N,
  input  logic              UB_N,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              protocol_err
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam int          HALF     = DATA_W / 2;
  localparam logic [15:0] C_RD_LAT = 16'(RD_LAT);
  localparam logic [15:0] C_WR_CYC = 16'(WR_CYCLES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    READ_DRIVE = 3'd2,
    WRITE_WAIT = 3'd3,
    WRITE_HOLD = 3'd4
  } state_t;

  state_t              r_state, w_nstate;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [15:0]         r_wr_cnt, r_rd_cnt;
  logic                r_perr;
  logic                r_drv_lo, r_drv_hi;
  logic [DATA_W-1:0]   r_dout;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_rd, w_wr, w_conf, w_same;
  logic                w_latch, w_commit, w_drive, w_rd_inc;
  logic [IDX_W-1:0]    w_idx;

  assign w_rd      = ~CE_N & ~OE_N &  WE_N;
  assign w_wr      = ~CE_N &  OE_N & ~WE_N;
  assign w_conf    = ~CE_N & ~OE_N & ~WE_N;
  assign w_same    = (addr == r_addr);
  assign w_idx     = addr[IDX_W-1:0];
  assign w_cnt_inc = r_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_perr   <= 1'b0;
      r_drv_lo <= 1'b0;
      r_drv_hi <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_cnt_nxt;
      r_perr   <= r_perr | w_conf;
      r_drv_lo <= w_drive & ~LB_N;
      r_drv_hi <= w_drive & ~UB_N;
      if (w_latch)  r_addr   <= addr;
      if (w_commit) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rd_inc) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_drive)  r_dout   <= r_mem[w_idx];
    end
  end

  // Storage survives reset, so it lives in its own unreset process.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (!LB_N) r_mem[w_idx][HALF-1:0]      <= data[HALF-1:0];
      if (!UB_N) r_mem[w_idx][DATA_W-1:HALF] <= data[DATA_W-1:HALF];
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_commit  = 1'b0;
    w_drive   = 1'b0;
    w_rd_inc  = 1'b0;
    case (r_state)
      IDLE, READ_DRIVE: begin
        if (w_rd && r_state == READ_DRIVE && w_same) begin
          w_drive = 1'b1;
        end else if (w_rd) begin
          w_latch   = 1'b1;
          w_cnt_nxt = 16'd1;
          if (C_RD_LAT == 16'd1) begin
            w_nstate = READ_DRIVE;
            w_drive  = 1'b1;
            w_rd_inc = 1'b1;
          end else begin
            w_nstate = READ_WAIT;
          end
        end else if (w_wr && r_state == IDLE) begin
          w_latch   = 1'b1;
          w_cnt_nxt = 16'd1;
          if (C_WR_CYC == 16'd1) begin
            w_commit = 1'b1;
            w_nstate = WRITE_HOLD;
          end else begin
            w_nstate = WRITE_WAIT;
          end
        end else begin
          // A write seen while driving only releases the bus; it restarts from IDLE.
          w_nstate = IDLE;
        end
      end
      READ_WAIT: begin
        if (w_rd && w_same) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= C_RD_LAT) begin
            w_nstate = READ_DRIVE;
            w_drive  = 1'b1;
            w_rd_inc = 1'b1;
          end
        end else if (w_rd) begin
          w_latch   = 1'b1;
          w_cnt_nxt = 16'd1;
        end else begin
          w_nstate = IDLE;
        end
      end
      WRITE_WAIT: begin
        if (w_wr && w_same) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= C_WR_CYC) begin
            w_commit = 1'b1;
            w_nstate = WRITE_HOLD;
          end
        end else if (w_wr) begin
          w_latch   = 1'b1;
          w_cnt_nxt = 16'd1;
        end else begin
          w_nstate = IDLE;
        end
      end
      WRITE_HOLD: begin
        if (!w_wr) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  assign data[HALF-1:0]      = r_drv_lo ? r_dout[HALF-1:0]      : {HALF{1'bz}};
  assign data[DATA_W-1:HALF] = r_drv_hi ? r_dout[DATA_W-1:HALF] : {HALF{1'bz}};

  assign wr_count     = r_wr_cnt;
  assign rd_count     = r_rd_cnt;
  assign protocol_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_responder: scoreboard bench for sram_responder (pulled-up bus).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sram_responder;

  localparam logic [63:0] C_ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] C_DB   = 64'hDEADBEEF_CAFEF00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CE_N = 1'b1, OE_N = 1'b1, WE_N = 1'b1, LB_N = 1'b0, UB_N = 1'b0;
  logic [19:0] addr = '0;
  logic [63:0] tb_dout = '0;
  logic        tb_oe = 1'b0;
  tri1  [63:0] data;
  logic [15:0] wr_count, rd_count;
  logic        protocol_err;

  assign data = tb_oe ? tb_dout : 64'bz;

  sram_responder dut (
    .clk(clk), .rst(rst), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
    .LB_N(LB_N), .UB_N(UB_N), .addr(addr), .data(data),
    .wr_count(wr_count), .rd_count(rd_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] exp_wr = '0;
  logic [15:0] exp_rd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    CE_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; LB_N = 1'b0; UB_N = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [63:0] d,
                          input logic lb, input logic ub, input int edges);
    CE_N = 1'b0; OE_N = 1'b1; WE_N = 1'b0; LB_N = lb; UB_N = ub;
    addr = a; tb_dout = d; tb_oe = 1'b1;
    repeat (edges) tick();
    if (edges >= 2) exp_wr++;
    go_idle();
    tick();
  endtask

  task automatic start_read(input logic [19:0] a, input logic lb, input logic ub);
    CE_N = 1'b0; OE_N = 1'b0; WE_N = 1'b1; LB_N = lb; UB_N = ub; addr = a; tb_oe = 1'b0;
  endtask

  task automatic do_read(input logic [19:0] a, input logic lb, input logic ub,
                         input logic [63:0] exp, input string tag);
    start_read(a, lb, ub);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    check({tag, "_wait"}, data, C_ALL1);
    tick();
    exp_rd++;
    check(tag_q.pop_front(), data, exp_q.pop_front());
    check({tag, "_rdcnt"}, {48'd0, rd_count}, {48'd0, exp_rd});
    go_idle();
    tick();
    check({tag, "_rel"}, data, C_ALL1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_wr", {48'd0, wr_count}, 64'd0);
    check("rst_rd", {48'd0, rd_count}, 64'd0);
    check("rst_perr", {63'd0, protocol_err}, 64'd0);
    check("rst_bus", data, C_ALL1);

    // Basic write then read
    do_write(20'h00010, C_DB, 1'b0, 1'b0, 2);
    check("wr1_cnt", {48'd0, wr_count}, {48'd0, exp_wr});
    do_read(20'h00010, 1'b0, 1'b0, C_DB, "rd1");

    // Byte lanes
    do_write(20'h5, C_ALL1, 1'b0, 1'b0, 2);
    do_write(20'h5, 64'd0, 1'b0, 1'b1, 2);
    check("lane_wrcnt", {48'd0, wr_count}, {48'd0, exp_wr});
    do_read(20'h5, 1'b0, 1'b0, 64'hFFFFFFFF_00000000, "lane_rd");
    do_read(20'h5, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, "lane_lbz5");
    do_read(20'h10, 1'b1, 1'b0, 64'hDEADBEEF_FFFFFFFF, "lane_lbz");
    do_read(20'h10, 1'b0, 1'b1, 64'hFFFFFFFF_CAFEF00D, "lane_ubz");

    // Short pulses
    do_write(20'h10, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1);
    check("short_wr", {48'd0, wr_count}, {48'd0, exp_wr});
    start_read(20'h10, 1'b0, 1'b0);
    tick();
    go_idle();
    check("short_rd_bus0", data, C_ALL1);
    tick();
    check("short_rd_bus1", data, C_ALL1);
    check("short_rdcnt", {48'd0, rd_count}, {48'd0, exp_rd});
    do_read(20'h10, 1'b0, 1'b0, C_DB, "short_keep");

    // Conflict, including one that aborts a pending write
    CE_N = 1'b0; OE_N = 1'b1; WE_N = 1'b0; addr = 20'h10; tb_dout = 64'h0; tb_oe = 1'b1;
    tick();
    OE_N = 1'b0; tb_oe = 1'b0;
    tick();
    check("conf_perr", {63'd0, protocol_err}, 64'd1);
    check("conf_bus", data, C_ALL1);
    go_idle();
    tick();
    tick();
    check("conf_sticky", {63'd0, protocol_err}, 64'd1);
    check("conf_wrcnt", {48'd0, wr_count}, {48'd0, exp_wr});
    do_read(20'h10, 1'b0, 1'b0, C_DB, "conf_nocommit");

    // Address change while driving
    do_write(20'h3, 64'h3333_3333_3333_3333, 1'b0, 1'b0, 2);
    do_write(20'h4, 64'h4444_4444_4444_4444, 1'b0, 1'b0, 2);
    start_read(20'h3, 1'b0, 1'b0);
    tick();
    tick();
    exp_rd++;
    check("ach_a3", data, 64'h3333_3333_3333_3333);
    addr = 20'h4;
    tick();
    check("ach_gap", data, C_ALL1);
    tick();
    exp_rd++;
    check("ach_a4", data, 64'h4444_4444_4444_4444);
    check("ach_rdcnt", {48'd0, rd_count}, {48'd0, exp_rd});
    go_idle();
    tick();

    // Asynchronous reset while driving
    start_read(20'h10, 1'b0, 1'b0);
    tick();
    tick();
    check("rr_drive", data, C_DB);
    #2 rst = 1'b1;
    #1;
    exp_wr = '0;
    exp_rd = '0;
    check("rr_bus", data, C_ALL1);
    check("rr_wr", {48'd0, wr_count}, 64'd0);
    check("rr_rd", {48'd0, rd_count}, 64'd0);
    check("rr_perr", {63'd0, protocol_err}, 64'd0);
    go_idle();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    do_read(20'h00010, 1'b0, 1'b0, C_DB, "rr_keep");
    do_read(20'h00410, 1'b0, 1'b0, C_DB, "alias");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
